// File: rtl/idex_pkg.sv
// ---------------------------------------------------------------------------
// idex_pkg : shared request type and widths for the ID/EX and EX/MEM stages.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package idex_pkg;

  localparam int DEFAULT_ADDR_W = 20;
  // datarw, dataena, IP_write, IP_read ride along with the address
  localparam int REQ_FLAG_W     = 4;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] address;
    logic                      datarw;
    logic                      dataena;
    logic                      IP_write;
    logic                      IP_read;
  } mem_req_t;

endpackage : idex_pkg

`default_nettype wire

// File: rtl/idex_slot.sv
// ---------------------------------------------------------------------------
// idex_slot : one valid+payload register of the request pipe.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module idex_slot #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         hold_i,
  input  logic         load_i,
  input  logic         empty_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  // Emptied slots drop to zero so no stale strobe reaches the output.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (!hold_i) begin
      if (load_i) begin
        valid_d = 1'b1;
        data_d  = data_i;
      end else if (empty_i) begin
        valid_d = 1'b0;
        data_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule : idex_slot

`default_nettype wire

// File: rtl/idex_mem_pipe.sv
// ---------------------------------------------------------------------------
// idex_mem_pipe : STAGES-deep ID/EX memory-request pipe with valid/ready,
//                 stall, flush and per-slot bubble collapsing.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module idex_mem_pipe
  import idex_pkg::*;
#(
  parameter int ADDR_W = idex_pkg::DEFAULT_ADDR_W,
  parameter int STAGES = 2,
  parameter int OCC_W  = $clog2(STAGES+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] address_in,
  input  logic              datarw_in,
  input  logic              dataena_in,
  input  logic              IP_write_in,
  input  logic              IP_read_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] address_out,
  output logic              datarw_out,
  output logic              dataena_out,
  output logic              IP_write_out,
  output logic              IP_read_out,
  output logic [OCC_W-1:0]  occupancy
);

  localparam int PAY_W = ADDR_W + REQ_FLAG_W;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] empty;
  logic [PAY_W-1:0]  pay [STAGES];
  logic [PAY_W-1:0]  pay_in;
  logic              accept;
  logic              pop;
  logic [OCC_W-1:0]  occ_q, occ_d;

  assign pay_in = {address_in, datarw_in, dataena_in, IP_write_in, IP_read_in};

  // Advance ripples from the output end so a slot can move into a
  // successor that is itself moving on in the same cycle.
  always_comb begin
    adv         = '0;
    adv[STAGES-1] = v[STAGES-1] & out_ready & ~stall_in;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = v[k] & (~v[k+1] | adv[k+1]) & ~stall_in;
    end
  end

  assign in_ready = ~rst & ~stall_in & ~flush & (~v[0] | adv[0]);
  assign accept   = in_valid & in_ready;
  assign pop      = adv[STAGES-1];

  always_comb begin
    load  = '0;
    empty = '0;
    load[0] = accept;
    for (int k = 1; k < STAGES; k++) begin
      load[k] = adv[k-1];
    end
    empty = adv & ~load;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    logic [PAY_W-1:0] slot_d;
    if (k == 0) begin : g_head
      assign slot_d = pay_in;
    end else begin : g_body
      assign slot_d = pay[k-1];
    end

    idex_slot #(
      .W (PAY_W)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (flush),
      .hold_i  (stall_in),
      .load_i  (load[k]),
      .empty_i (empty[k]),
      .data_i  (slot_d),
      .valid_o (v[k]),
      .data_o  (pay[k])
    );
  end

  always_comb begin
    occ_d = occ_q;
    if (accept && !pop) begin
      occ_d = occ_q + 1'b1;
    end else if (!accept && pop) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
  assign out_valid = v[STAGES-1];
  assign {address_out, datarw_out, dataena_out, IP_write_out, IP_read_out} = pay[STAGES-1];

endmodule : idex_mem_pipe

`default_nettype wire

// File: tb/tb_idex_mem_pipe.sv
// ---------------------------------------------------------------------------
// tb_idex_mem_pipe : directed checks of idex_mem_pipe at STAGES=2 and 3.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_idex_mem_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        flush;
  logic        in_valid;
  logic [19:0] address_in;
  logic        datarw_in, dataena_in, IP_write_in, IP_read_in;
  logic        out_ready;

  logic        in_ready2, out_valid2, datarw2, dataena2, ipw2, ipr2;
  logic [19:0] addr2;
  logic [1:0]  occ2;
  logic        in_ready3, out_valid3, datarw3, dataena3, ipw3, ipr3;
  logic [19:0] addr3;
  logic [1:0]  occ3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  idex_mem_pipe #(.ADDR_W(20), .STAGES(2)) u_dut2 (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2), .address_in(address_in),
    .datarw_in(datarw_in), .dataena_in(dataena_in), .IP_write_in(IP_write_in),
    .IP_read_in(IP_read_in), .out_valid(out_valid2), .out_ready(out_ready),
    .address_out(addr2), .datarw_out(datarw2), .dataena_out(dataena2),
    .IP_write_out(ipw2), .IP_read_out(ipr2), .occupancy(occ2)
  );

  idex_mem_pipe #(.ADDR_W(20), .STAGES(3)) u_dut3 (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready3), .address_in(address_in),
    .datarw_in(datarw_in), .dataena_in(dataena_in), .IP_write_in(IP_write_in),
    .IP_read_in(IP_read_in), .out_valid(out_valid3), .out_ready(out_ready),
    .address_out(addr3), .datarw_out(datarw3), .dataena_out(dataena3),
    .IP_write_out(ipw3), .IP_read_out(ipr3), .occupancy(occ3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // flags = {datarw, dataena, IP_write, IP_read}
  task automatic put(input logic vld, input logic [19:0] a, input logic [3:0] f);
    in_valid   = vld;
    address_in = a;
    {datarw_in, dataena_in, IP_write_in, IP_read_in} = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall_in = 1'b0; flush = 1'b0; out_ready = 1'b0;
    put(1'b1, 20'h11111, 4'hF);

    // reset
    tick(); settle();
    check("rst_in_ready", in_ready2, 0);
    check("rst_out_valid", out_valid2, 0);
    check("rst_addr", addr2, 0);
    check("rst_dataena", dataena2, 0);
    check("rst_ipw", ipw2, 0);
    check("rst_occ", occ2, 0);
    check("rst_occ3", occ3, 0);
    tick();
    rst = 1'b0; put(1'b0, 20'h0, 4'h0); settle();
    check("post_rst_ready", in_ready2, 1);
    check("post_rst_occ", occ2, 0);

    // latency and back-to-back throughput
    out_ready = 1'b1;
    put(1'b1, 20'hABCDE, 4'b0001); settle();
    check("lat_ready", in_ready2, 1);
    tick(); put(1'b1, 20'h12345, 4'b1100); settle();
    check("lat_n1_valid", out_valid2, 0);
    check("lat_n1_occ", occ2, 1);
    tick(); put(1'b1, 20'h0F0F0, 4'b0010); settle();
    check("lat_a_valid", out_valid2, 1);
    check("lat_a_addr", addr2, 20'hABCDE);
    check("lat_a_ipr", ipr2, 1);
    check("lat_a_rw", datarw2, 0);
    check("lat_occ2", occ2, 2);
    tick(); put(1'b0, 20'h0, 4'h0); settle();
    check("b2b_b_addr", addr2, 20'h12345);
    check("b2b_b_rw", datarw2, 1);
    check("b2b_b_ena", dataena2, 1);
    tick(); settle();
    check("b2b_c_addr", addr2, 20'h0F0F0);
    check("b2b_c_ipw", ipw2, 1);
    check("b2b_c_occ", occ2, 1);
    tick(); settle();
    check("drain_valid", out_valid2, 0);
    check("drain_addr", addr2, 0);
    check("drain_ipw", ipw2, 0);
    check("drain_occ", occ2, 0);

    // backpressure
    out_ready = 1'b0;
    put(1'b1, 20'h0D0D0, 4'b0100); tick();
    put(1'b1, 20'h0E0E0, 4'b0100); tick();
    put(1'b1, 20'h0F00F, 4'b0100); settle();
    check("bp_full_ready", in_ready2, 0);
    check("bp_full_occ", occ2, 2);
    check("bp_full_addr", addr2, 20'h0D0D0);
    tick(); settle();
    check("bp_hold_occ", occ2, 2);
    check("bp_hold_addr", addr2, 20'h0D0D0);
    out_ready = 1'b1; settle();
    check("bp_popaccept_ready", in_ready2, 1);
    tick(); put(1'b0, 20'h0, 4'h0); settle();
    check("bp_e_addr", addr2, 20'h0E0E0);
    check("bp_same_occ", occ2, 2);
    tick(); settle();
    check("bp_f_addr", addr2, 20'h0F00F);
    tick(); settle();
    check("bp_empty_valid", out_valid2, 0);
    check("bp_empty_occ", occ2, 0);

    // stall
    out_ready = 1'b0;
    put(1'b1, 20'h0AAAA, 4'b1000); tick();
    put(1'b1, 20'h05555, 4'b1000); tick();
    put(1'b0, 20'h0, 4'h0);
    stall_in = 1'b1; out_ready = 1'b1; settle();
    for (int i = 0; i < 3; i++) begin
      check("stall_ready", in_ready2, 0);
      tick(); settle();
      check("stall_valid", out_valid2, 1);
      check("stall_addr", addr2, 20'h0AAAA);
      check("stall_occ", occ2, 2);
    end
    stall_in = 1'b0;
    tick(); settle();
    check("unstall_addr", addr2, 20'h05555);
    check("unstall_occ", occ2, 1);
    tick(); settle();
    check("unstall_occ0", occ2, 0);

    // flush with a beat presented
    out_ready = 1'b0;
    put(1'b1, 20'h01111, 4'b0010); tick();
    put(1'b1, 20'h02222, 4'b0010); tick();
    put(1'b1, 20'h0DEAD, 4'hF); flush = 1'b1; settle();
    check("flush_ready", in_ready2, 0);
    check("flush_pre_occ", occ2, 2);
    tick();
    flush = 1'b0; put(1'b0, 20'h0, 4'h0); out_ready = 1'b1; settle();
    check("flush_valid", out_valid2, 0);
    check("flush_addr", addr2, 0);
    check("flush_ipw", ipw2, 0);
    check("flush_occ", occ2, 0);
    tick(); tick(); settle();
    check("flush_dropped", out_valid2, 0);

    // flush wins over stall
    out_ready = 1'b0;
    put(1'b1, 20'h03333, 4'b0001); tick();
    put(1'b0, 20'h0, 4'h0); tick();
    stall_in = 1'b1; flush = 1'b1; tick();
    stall_in = 1'b0; flush = 1'b0; settle();
    check("flush_stall_occ", occ2, 0);
    check("flush_stall_valid", out_valid2, 0);

    // bubble collapse, STAGES=3
    rst = 1'b1; tick();
    rst = 1'b0; out_ready = 1'b0;
    put(1'b1, 20'h0CAFE, 4'b0100); tick();
    put(1'b0, 20'h0, 4'h0); settle();
    check("bub_s0_valid", out_valid3, 0);
    check("bub_s0_ena", dataena3, 0);
    check("bub_s0_occ", occ3, 1);
    tick(); settle();
    check("bub_s1_valid", out_valid3, 0);
    check("bub_s1_ena", dataena3, 0);
    tick(); settle();
    check("bub_s2_valid", out_valid3, 1);
    check("bub_s2_addr", addr3, 20'h0CAFE);
    check("bub_s2_ena", dataena3, 1);
    tick(); settle();
    check("bub_hold_valid", out_valid3, 1);
    check("bub_hold_occ", occ3, 1);
    out_ready = 1'b1; tick(); settle();
    check("bub_pop_valid", out_valid3, 0);
    check("bub_pop_ena", dataena3, 0);
    check("bub_pop_occ", occ3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_idex_mem_pipe

`default_nettype wire
